// File: rtl/seg7_scan_reader.sv
// Multiplexed 7-segment bus reader: filters strobes, decodes segments back to BCD.
// Optional hex glyph support (A..F) when SEG7_HEX_EN is defined.
module seg7_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  state_t                  state, state_nx;
  logic [6:0]              samp_seg;
  logic [NUM_DIGITS-1:0]   samp_sel;
  logic [3:0]              cnt;
  logic [NUM_DIGITS-1:0]   seen;

  logic                    same, accept;
  logic                    sel_onehot, sel_multi;
  logic                    seg_legal;
  logic [3:0]              seg_val;
  logic                    complete, err_set;

  // Returns {legal, value}; blank (00) is reported as not legal.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'b0_0000;
    case (s)
      7'h7E: r = {1'b1, 4'd0};
      7'h30: r = {1'b1, 4'd1};
      7'h6D: r = {1'b1, 4'd2};
      7'h79: r = {1'b1, 4'd3};
      7'h33: r = {1'b1, 4'd4};
      7'h5B: r = {1'b1, 4'd5};
      7'h5F: r = {1'b1, 4'd6};
      7'h70: r = {1'b1, 4'd7};
      7'h72: r = {1'b1, 4'd7};
      7'h7F: r = {1'b1, 4'd8};
      7'h7B: r = {1'b1, 4'd9};
      7'h73: r = {1'b1, 4'd9};
`ifdef SEG7_HEX_EN
      7'h77: r = {1'b1, 4'd10};
      7'h1F: r = {1'b1, 4'd11};
      7'h4E: r = {1'b1, 4'd12};
      7'h3D: r = {1'b1, 4'd13};
      7'h4F: r = {1'b1, 4'd14};
      7'h47: r = {1'b1, 4'd15};
`else
      7'h1F: r = {1'b1, 4'd6};
`endif
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  assign same       = ({seg, dig_sel} == {samp_seg, samp_sel});
  // Accept exactly on the edge where the count reaches STABLE_CYCLES.
  assign accept     = same ? (cnt == STABLE_C - 4'd1) : (STABLE_C == 4'd1);
  assign sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
  assign sel_multi  = (dig_sel != '0) && !sel_onehot;
  assign {seg_legal, seg_val} = decode(seg);

  assign complete   = accept && sel_onehot && ((seen | dig_sel) == '1);
  assign err_set    = accept && (sel_multi || (sel_onehot && !seg_legal && (seg != 7'h00)));
  assign frame_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_seg <= '0;
      samp_sel <= '0;
      cnt      <= '0;
    end else if (!same) begin
      samp_seg <= seg;
      samp_sel <= dig_sel;
      cnt      <= 4'd1;
    end else if (cnt != STABLE_C) begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (complete)                   state_nx = DONE;
        else if (accept && sel_onehot)  state_nx = COLLECT;
      end
      COLLECT: if (complete) state_nx = DONE;
      DONE:    state_nx = complete ? DONE : COLLECT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd         <= '0;
      digit_valid <= '0;
      seen        <= '0;
      err         <= 1'b0;
    end else begin
      if (accept && sel_onehot) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (dig_sel[i]) begin
            if (seg_legal) begin
              bcd[4*i +: 4]  <= seg_val;
              digit_valid[i] <= 1'b1;
            end else begin
              digit_valid[i] <= 1'b0;
            end
          end
        end
        seen <= complete ? '0 : (seen | dig_sel);
      end
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader: a hold-level model predicts outputs on each accept edge.
module tb_seg7_scan_reader;
  localparam int ND = 4;
  localparam int SC = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg;
  logic [ND-1:0] dig_sel;
  logic          err_clr;
  logic [4*ND-1:0] bcd;
  logic [ND-1:0] digit_valid;
  logic          frame_done;
  logic          err;

  seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel), .err_clr(err_clr),
    .bcd(bcd), .digit_valid(digit_valid), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  valid;
    logic        err;
    logic        fd;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   entry  = 0;

  logic [15:0] m_bcd;
  logic [3:0]  m_valid, m_seen;
  logic        m_err, m_fd;
  int          m_frames = 0;
  int          fd_pulses = 0;

  localparam logic [6:0] GLYPH [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  localparam logic [6:0] HEXG  [6]  = '{7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  always @(negedge clk) if (frame_done) fd_pulses++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (entry %0d): got %h expected %h", tag, entry, act, exp);
    end
  endtask

  function automatic void tb_decode(input logic [6:0] s, output logic ok, output logic [3:0] v);
    ok = 1'b0; v = 4'd0;
    for (int i = 0; i < 10; i++) if (s == GLYPH[i]) begin ok = 1'b1; v = 4'(i); end
    if (s == 7'h72) begin ok = 1'b1; v = 4'd7; end
    if (s == 7'h73) begin ok = 1'b1; v = 4'd9; end
`ifdef SEG7_HEX_EN
    for (int i = 0; i < 6; i++) if (s == HEXG[i]) begin ok = 1'b1; v = 4'(10 + i); end
`else
    if (s == 7'h1F) begin ok = 1'b1; v = 4'd6; end
`endif
  endfunction

  task automatic model_reset();
    m_bcd = '0; m_valid = '0; m_seen = '0; m_err = 1'b0; m_fd = 1'b0;
  endtask

  task automatic model_accept(input logic [3:0] sel, input logic [6:0] s);
    logic ok; logic [3:0] v;
    m_fd = 1'b0;
    if (sel == '0) return;
    if ($countones(sel) != 1) begin m_err = 1'b1; return; end
    tb_decode(s, ok, v);
    for (int i = 0; i < ND; i++) begin
      if (sel[i]) begin
        if (ok) begin m_bcd[4*i +: 4] = v; m_valid[i] = 1'b1; end
        else begin m_valid[i] = 1'b0; if (s != 7'h00) m_err = 1'b1; end
      end
    end
    m_seen = m_seen | sel;
    if (m_seen == 4'hF) begin m_fd = 1'b1; m_seen = '0; m_frames++; end
  endtask

  task automatic compare_pop();
    exp_t e;
    e = q.pop_front();
    check("bcd",   32'(bcd),         32'(e.bcd));
    check("valid", 32'(digit_valid), 32'(e.valid));
    check("err",   32'(err),         32'(e.err));
    check("fdone", 32'(frame_done),  32'(e.fd));
    entry++;
  endtask

  task automatic push_model();
    exp_t e;
    e.bcd = m_bcd; e.valid = m_valid; e.err = m_err; e.fd = m_fd;
    q.push_back(e);
  endtask

  // Holds one pattern for n edges; expectations are pushed before the accept and final edges.
  task automatic hold(input logic [3:0] sel, input logic [6:0] s, input int n);
    bit pushed;
    dig_sel = sel; seg = s;
    for (int k = 0; k < n; k++) begin
      pushed = 1'b0;
      if (k == SC - 1) model_accept(sel, s);
      else             m_fd = 1'b0;
      if (k == SC - 1 || k == n - 1) begin push_model(); pushed = 1'b1; end
      @(posedge clk); #1;
      if (pushed) compare_pop();
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    m_err = 1'b0; m_fd = 1'b0;
    push_model();
    @(posedge clk); #1;
    err_clr = 1'b0;
    compare_pop();
  endtask

  initial begin
    rst_n = 1'b0; seg = '0; dig_sel = '0; err_clr = 1'b0;
    model_reset();
    #12;
    check("rst_bcd",   32'(bcd), 32'(m_bcd));
    check("rst_valid", 32'(digit_valid), 32'(m_valid));
    check("rst_err",   32'(err), 32'(m_err));
    check("rst_fdone", 32'(frame_done), 32'(m_fd));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    hold(4'b0001, 7'h7E, 3);
    hold(4'b0000, 7'h00, 2);

    hold(4'b0001, 7'h30, 3); hold(4'b0000, 7'h00, 2);
    hold(4'b0010, 7'h6D, 5); hold(4'b0000, 7'h00, 2);
    hold(4'b0100, 7'h79, 3); hold(4'b0000, 7'h00, 2);
    hold(4'b1000, 7'h33, 3); hold(4'b0000, 7'h00, 2);

    hold(4'b0010, 7'h5B, 2); hold(4'b0000, 7'h00, 2);

    hold(4'b0100, 7'h7A, 3); hold(4'b0000, 7'h00, 3);
    clear_err();

    hold(4'b0011, 7'h7F, 3); hold(4'b0000, 7'h00, 2);
    hold(4'b0001, 7'h72, 3);
    dig_sel = '0; seg = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_bcd",   32'(bcd), 32'(m_bcd));
    check("mid_rst_valid", 32'(digit_valid), 32'(m_valid));
    check("mid_rst_err",   32'(err), 32'(m_err));
    check("mid_rst_fdone", 32'(frame_done), 32'(m_fd));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    hold(4'b0010, 7'h73, 3); hold(4'b0000, 7'h00, 2);
    hold(4'b0100, 7'h5F, 3); hold(4'b0000, 7'h00, 2);
    hold(4'b1000, 7'h70, 3); hold(4'b0000, 7'h00, 2);
    hold(4'b0001, 7'h7B, 3); hold(4'b0000, 7'h00, 2);

    hold(4'b0010, 7'h1F, 3); hold(4'b0000, 7'h00, 2);
    hold(4'b1000, 7'h4F, 3); hold(4'b0000, 7'h00, 2);
    hold(4'b0100, 7'h00, 3); hold(4'b0000, 7'h00, 2);

    check("frame_pulses", 32'(fd_pulses), 32'(m_frames));
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
